filter_cfg_sequencer: RTL and testbench

//  Sequences audio filter coefficient changes between the user filter switch and the IIR datapath.

---
 rtl/filters_pkg.sv | 28 ++
 rtl/filter_sw_stabilizer.sv | 34 +++
 rtl/filter_cfg_sequencer.sv | 151 +++++++++++++++
 tb/tb_filter_cfg_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/filters_pkg.sv
// Shared types for the audio filter coefficient path: the coefficient set, sequencer states and gain constants.
package filters_pkg;

    localparam int FLT_IDX_W  = 4;
    localparam int FLT_GAIN_W = 9;
    localparam logic [FLT_GAIN_W-1:0] GAIN_UNITY = 9'd256;

    typedef struct packed {
        logic        [31:0] rate;
        logic        [39:0] cx;
        logic        [7:0]  cx0;
        logic        [7:0]  cx1;
        logic        [7:0]  cx2;
        logic signed [23:0] cy0;
        logic signed [23:0] cy1;
        logic signed [23:0] cy2;
    } flt_coef_t;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        SELECT,
        LOAD,
        FLUSH,
        FADE_IN
    } flt_seq_state_e;

endpackage

// File: rtl/filter_sw_stabilizer.sv
// Accepts a new filter switch value only after it has held steady for STABLE_CYC clocks.
module filter_sw_stabilizer
    import filters_pkg::*;
#(
    parameter int STABLE_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [FLT_IDX_W-1:0] afilter_sw,
    output logic [FLT_IDX_W-1:0] req_idx
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    logic [FLT_IDX_W-1:0] sw_p0;
    logic [CNT_W-1:0]     hold_cnt;

    // Stage p0: last seen switch value and how long it has held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_p0    <= '0;
            hold_cnt <= '0;
            req_idx  <= '0;
        end else if (afilter_sw != sw_p0) begin
            sw_p0    <= afilter_sw;
            hold_cnt <= '0;
        end else if (hold_cnt != CNT_W'(STABLE_CYC - 1)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            req_idx  <= sw_p0;
        end
    end

endmodule

// File: rtl/filter_cfg_sequencer.sv
// Mutes, reloads and flushes the IIR filter when the requested filter changes.
// FLT_SOFT_FADE_EN selects ramped fades; otherwise the gain steps between 0 and unity.
module filter_cfg_sequencer
    import filters_pkg::*;
#(
    parameter int NUM_FILTERS = 9,
    parameter int ROM_LAT     = 1,
    parameter int STABLE_CYC  = 1024,
    parameter int FLUSH_CYC   = 16,
    parameter int GAIN_W      = FLT_GAIN_W,
    parameter int FADE_STEP   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [FLT_IDX_W-1:0] afilter_sw,
    input  logic                 sample_ce,
    output logic [FLT_IDX_W-1:0] rom_sel,
    input  flt_coef_t            rom_coef,
    output flt_coef_t            flt_coef,
    output logic                 flt_clear,
    output logic [GAIN_W-1:0]    att_gain,
    output logic [FLT_IDX_W-1:0] active_idx,
    output logic                 busy
);

`ifdef FLT_SOFT_FADE_EN
    localparam bit SOFT_FADE = 1'b1;
`else
    localparam bit SOFT_FADE = 1'b0;
`endif

    localparam int CNT_MAX = (FLUSH_CYC > ROM_LAT) ? FLUSH_CYC : ROM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam logic [GAIN_W-1:0] UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [GAIN_W-1:0] STEP  = GAIN_W'(FADE_STEP);

    flt_seq_state_e       state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [FLT_IDX_W-1:0] req_idx, tgt, rom_sel_nxt;
    logic [GAIN_W-1:0]    gain_nxt;
    logic                 clear_nxt;
    logic                 load_en;

    function automatic logic [GAIN_W-1:0] gain_dec(input logic [GAIN_W-1:0] g);
        return (g > STEP) ? g - STEP : '0;
    endfunction

    function automatic logic [GAIN_W-1:0] gain_inc(input logic [GAIN_W-1:0] g);
        return (g >= UNITY - STEP) ? UNITY : g + STEP;
    endfunction

    filter_sw_stabilizer #(
        .STABLE_CYC (STABLE_CYC)
    ) u_stab (
        .clk        (clk),
        .reset_n    (reset_n),
        .afilter_sw (afilter_sw),
        .req_idx    (req_idx)
    );

    assign tgt  = (int'(req_idx) < NUM_FILTERS) ? req_idx : '0;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SELECT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rom_sel_nxt = rom_sel;
        gain_nxt    = att_gain;
        clear_nxt   = flt_clear;
        load_en     = 1'b0;
        unique case (state)
            IDLE: begin
                clear_nxt = 1'b0;
                if (tgt != active_idx) begin
                    state_nxt = FADE_OUT;
                    if (!SOFT_FADE) gain_nxt = '0;
                end
            end
            FADE_OUT: begin
                if (!SOFT_FADE || att_gain == '0) begin
                    gain_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = SELECT;
                end else if (sample_ce) begin
                    gain_nxt = gain_dec(att_gain);
                end
            end
            SELECT: begin
                // index is captured once; later requests wait for FADE_IN/IDLE
                if (cnt == '0) rom_sel_nxt = tgt;
                if (cnt == CNT_W'(ROM_LAT)) state_nxt = LOAD;
                else                        cnt_nxt   = cnt + 1'b1;
            end
            LOAD: begin
                load_en   = 1'b1;
                clear_nxt = 1'b1;
                cnt_nxt   = '0;
                state_nxt = FLUSH;
            end
            FLUSH: begin
                if (sample_ce) begin
                    if (cnt == CNT_W'(FLUSH_CYC - 1)) begin
                        clear_nxt = 1'b0;
                        state_nxt = FADE_IN;
                        if (!SOFT_FADE) gain_nxt = UNITY;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FADE_IN: begin
                if (tgt != active_idx) begin
                    state_nxt = FADE_OUT;
                    if (!SOFT_FADE) gain_nxt = '0;
                end else if (!SOFT_FADE || att_gain == UNITY) begin
                    state_nxt = IDLE;
                end else if (sample_ce) begin
                    gain_nxt = gain_inc(att_gain);
                end
            end
            default: state_nxt = SELECT;
        endcase
    end

    // Stage p0: registered outputs and coefficient latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            rom_sel    <= '0;
            att_gain   <= '0;
            flt_clear  <= 1'b1;
            active_idx <= '0;
            flt_coef   <= '0;
        end else begin
            cnt       <= cnt_nxt;
            rom_sel   <= rom_sel_nxt;
            att_gain  <= gain_nxt;
            flt_clear <= clear_nxt;
            if (load_en) begin
                flt_coef   <= rom_coef;
                active_idx <= rom_sel;
            end
        end
    end

endmodule

// File: tb/tb_filter_cfg_sequencer.sv
// Directed bench for filter_cfg_sequencer with a one-cycle registered coefficient ROM model.
module tb_filter_cfg_sequencer;
    import filters_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      afilter_sw;
    logic            sample_ce;
    logic [3:0]      rom_sel;
    flt_coef_t       rom_q;
    flt_coef_t       flt_coef;
    logic            flt_clear;
    logic [8:0]      att_gain;
    logic [3:0]      active_idx;
    logic            busy;

    int        n_tests = 0;
    int        n_fail  = 0;
    int        viol    = 0;
    bit        ce_en   = 1'b1;
    int        ce_div  = 0;
    flt_coef_t coef_prev;

    always #5 clk = ~clk;

    filter_cfg_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .afilter_sw (afilter_sw),
        .sample_ce  (sample_ce),
        .rom_sel    (rom_sel),
        .rom_coef   (rom_q),
        .flt_coef   (flt_coef),
        .flt_clear  (flt_clear),
        .att_gain   (att_gain),
        .active_idx (active_idx),
        .busy       (busy)
    );

    function automatic flt_coef_t rom_fn(input logic [3:0] i);
        flt_coef_t c;
        c.rate = 32'hA000_0000 | {28'd0, i};
        c.cx   = {36'h1_2345_6789, i};
        c.cx0  = {4'h1, i};
        c.cx1  = {4'h2, i};
        c.cx2  = {4'h3, i};
        c.cy0  = 24'(-1000 * (int'(i) + 1));
        c.cy1  = 24'(2000 * int'(i));
        c.cy2  = 24'(-int'(i));
        return c;
    endfunction

    always @(posedge clk) rom_q <= rom_fn(rom_sel);

    initial begin
        sample_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ce_div    = (ce_div == 3) ? 0 : ce_div + 1;
            sample_ce = ce_en && (ce_div == 0);
        end
    end

    always @(negedge clk) begin
        if (flt_coef !== coef_prev && att_gain !== 9'd0) viol++;
        coef_prev = flt_coef;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        int cnt;
        bit flag;
        reset_n    = 1'b0;
        afilter_sw = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_rom_sel", rom_sel, 0);
        chk("rst_coef", flt_coef.rate, 0);
        chk("rst_clear", flt_clear, 1);
        chk("rst_gain", att_gain, 0);
        chk("rst_active", active_idx, 0);
        chk("rst_busy", busy, 1);

        // boot load of index 0
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("boot_coef_pre", flt_coef.rate, 0);
        @(negedge clk);
        chk("boot_coef_rom0", flt_coef.rate, 64'hA000_0000);
        chk("boot_clear", flt_clear, 1);
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        chk("boot_idle", busy, 0);
        chk("boot_gain", att_gain, 256);
        chk("boot_clear_off", flt_clear, 0);
        chk("boot_active", active_idx, 0);

        // short glitch on the switch
        flag = 1'b0;
        afilter_sw = 4'd3;
        repeat (500) begin @(negedge clk); if (busy) flag = 1'b1; end
        afilter_sw = 4'd0;
        repeat (1200) begin @(negedge clk); if (busy) flag = 1'b1; end
        chk("glitch_no_seq", flag, 0);

        // out-of-range index maps to 0, already active
        afilter_sw = 4'd12;
        repeat (1300) begin @(negedge clk); if (busy) flag = 1'b1; end
        chk("oor_no_seq", flag, 0);
        chk("oor_active", active_idx, 0);

        // switch to 4
        afilter_sw = 4'd4;
        n = 0;
        while (busy !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
        chk("sw4_start", busy, 1);
        chk("sw4_hold_min", (n >= 1000), 1);
`ifdef FLT_SOFT_FADE_EN
        chk("sw4_fade_start", att_gain, 256);
        cnt = 0; n = 0;
        while (att_gain !== 9'd0 && n < 1000) begin
            if (sample_ce) cnt++;
            @(negedge clk); n++;
        end
        chk("sw4_fade_ce", cnt, 32);
`else
        chk("sw4_mute", att_gain, 0);
`endif
        n = 0;
        while (flt_clear !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("sw4_coef", flt_coef.rate, 64'hA000_0004);
        chk("sw4_gain_at_load", att_gain, 0);
        chk("sw4_active", active_idx, 4);
        cnt = 0; n = 0;
        while (flt_clear === 1'b1 && n < 2000) begin
            if (sample_ce) cnt++;
            @(negedge clk); n++;
        end
        chk("sw4_flush_ce", cnt, 16);
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("sw4_idle", busy, 0);
        chk("sw4_gain", att_gain, 256);
        chk("sw4_cy0", flt_coef.cy0, -64'sd5000);
        chk("sw4_cx0", flt_coef.cx0, 8'h14);

        // request 6 accepted while FLUSH of 2 is stalled
        afilter_sw = 4'd2;
        n = 0;
        while (busy !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
        chk("sw2_start", busy, 1);
        afilter_sw = 4'd6;
        n = 0;
        while (flt_clear !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("sw2_loaded", active_idx, 2);
        chk("sw2_coef", flt_coef.rate, 64'hA000_0002);
        repeat (8) @(negedge clk);
        ce_en = 1'b0;
        repeat (1200) @(negedge clk);
        chk("stall_clear", flt_clear, 1);
        chk("stall_active", active_idx, 2);
        ce_en = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        chk("abort_idle", busy, 0);
        chk("abort_active", active_idx, 6);
        chk("abort_coef", flt_coef.rate, 64'hA000_0006);

        // reset while fading in towards 0
        afilter_sw = 4'd0;
        n = 0;
        while (busy !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
        n = 0;
        while (flt_clear !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (flt_clear !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        chk("fadein_reached", (busy === 1'b1 && flt_clear === 1'b0), 1);
`ifdef FLT_SOFT_FADE_EN
        repeat (6) @(negedge clk);
`endif
        reset_n = 1'b0;
        #1;
        chk("midrst_gain", att_gain, 0);
        chk("midrst_clear", flt_clear, 1);
        chk("midrst_coef", flt_coef.rate, 0);
        chk("midrst_busy", busy, 1);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        chk("reboot_idle", busy, 0);
        chk("reboot_coef", flt_coef.rate, 64'hA000_0000);
        chk("reboot_active", active_idx, 0);
        chk("reboot_gain", att_gain, 256);
        chk("coef_change_muted", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
